// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: RAM geometry, loader sync byte, loader FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sap_pkg;

  localparam int         RAM_DEPTH   = 16;
  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } loader_state_e;

endpackage

// File: rtl/mem_loader.sv
// Framed byte-stream loader (SYNC, LEN, data, CSUM) into SAP-1 program RAM; holds CPU until a good frame lands.
// Latency: RAM write one cycle after its data byte; done/err/cpu_hold update one cycle after the deciding byte.
// Backpressure: none, in_ready is tied high; in_valid low simply pauses the frame.
module mem_loader
  import sap_pkg::*;
#(
  parameter int                 ADDR_W = $clog2(RAM_DEPTH),
  parameter int                 DATA_W = 8,
  parameter logic [DATA_W-1:0]  SYNC   = LOADER_SYNC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [DATA_W:0] DEPTH_V = (DATA_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_REM = (ADDR_W + 1)'(1);

  loader_state_e     state;
  // One wider than the address so a full-depth LEN fits.
  logic [ADDR_W:0]   remain;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W-1:0] addr;

  logic              len_bad;
  logic [DATA_W-1:0] sum_next;

  // The loader never stalls the host link.
  assign in_ready = 1'b1;

  // LEN must lie in 1..DEPTH; the running sum wraps at the word width.
  assign len_bad  = (in_data == '0) || ({1'b0, in_data} > DEPTH_V);
  assign sum_next = sum + in_data;

  // Frame FSM, counters, checksum and the registered RAM/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_SYNC;
      remain    <= '0;
      sum       <= '0;
      addr      <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (in_valid) begin
        case (state)
          S_SYNC: begin
            // Anything but SYNC is line noise between frames.
            if (in_data == SYNC) begin
              state    <= S_LEN;
              done     <= 1'b0;
              err      <= 1'b0;
              cpu_hold <= 1'b1;
            end
          end
          S_LEN: begin
            if (len_bad) begin
              err   <= 1'b1;
              state <= S_SYNC;
            end else begin
              remain <= in_data[ADDR_W:0];
              sum    <= in_data;
              addr   <= '0;
              state  <= S_DATA;
            end
          end
          S_DATA: begin
            // A SYNC value here is payload, not a restart.
            ram_we    <= 1'b1;
            ram_addr  <= addr;
            ram_wdata <= in_data;
            sum       <= sum_next;
            addr      <= addr + 1'b1;
            remain    <= remain - ONE_REM;
            if (remain == ONE_REM) begin
              state <= S_CSUM;
            end
          end
          S_CSUM: begin
            // Partial writes of a rejected frame stay in RAM; the CPU stays held.
            if (sum_next == '0) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end
            state <= S_SYNC;
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed plus randomized frames checked against a frame-level model of the loader.
// Latency: expects writes one cycle after each data byte and status one cycle after CSUM/LEN.
// Backpressure: in_ready is expected high always; in_valid gaps are injected at random.
module tb_mem_loader;
  import sap_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;

  mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;

  wr_t        obs[$];
  logic [7:0] obs_mem[16];
  logic [7:0] exp_mem[16];

  // Cycle stamp for write-timing checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write the loader issues.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      obs.push_back('{int'(ram_addr), int'(ram_wdata), cyc});
      obs_mem[ram_addr] = ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Present one byte for one accepted cycle, optionally after random idle cycles.
  task automatic drive(input logic [7:0] b, input int gap_pct);
    for (int k = 0; k < 3 && int'($urandom_range(0, 99)) < gap_pct; k++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] good_csum(input int len, input logic [7:0] data[$]);
    int s;
    s = len;
    foreach (data[i]) s += data[i];
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // Send SYNC, LEN, data and CSUM (data/CSUM only if LEN is legal) and check the outcome.
  task automatic run_frame(input string name, input int len, input logic [7:0] data[$],
                           input logic [7:0] csum, input int gap);
    bit len_ok;
    bit good;
    int s;
    int n;
    len_ok = (len >= 1) && (len <= 16);
    s = len + csum;
    foreach (data[i]) s += data[i];
    good = len_ok && (s % 256 == 0);
    obs.delete();
    drive(LOADER_SYNC, gap);
    chk({name, ".hold_after_sync"}, 32'(cpu_hold), 32'd1);
    chk({name, ".done_cleared"}, 32'(done), 32'd0);
    chk({name, ".err_cleared"}, 32'(err), 32'd0);
    drive(8'(len), gap);
    if (len_ok) begin
      foreach (data[i]) drive(data[i], gap);
      drive(csum, gap);
    end
    chk({name, ".done"}, 32'(done), 32'(good));
    chk({name, ".err"}, 32'(err), 32'(!good));
    chk({name, ".cpu_hold"}, 32'(cpu_hold), 32'(!good));
    chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
    n = len_ok ? len : 0;
    chk({name, ".nwrites"}, 32'(obs.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({name, ".waddr"}, (i < obs.size()) ? 32'(obs[i].a) : 32'hFFFF_FFFF, 32'(i));
      chk({name, ".wdata"}, (i < obs.size()) ? 32'(obs[i].d) : 32'hFFFF_FFFF, 32'(data[i]));
      if (gap == 0 && i > 0 && i < obs.size())
        chk({name, ".b2b"}, 32'(obs[i].c - obs[i-1].c), 32'd1);
      exp_mem[i] = data[i];
    end
    if (n > 0 && obs.size() > 0)
      chk({name, ".last_wr_before_status"}, 32'(obs[obs.size()-1].c < cyc), 32'd1);
  endtask

  logic [7:0] d[$];
  logic [7:0] cs;
  int         len;

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 16; i++) begin
      obs_mem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.ram_we", 32'(ram_we), 32'd0);
    chk("rst.ram_addr", 32'(ram_addr), 32'd0);
    chk("rst.ram_wdata", 32'(ram_wdata), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Good 3-byte frame behind a leading junk byte.
    drive(8'h00, 0);
    chk("junk.no_write", 32'(ram_we), 32'd0);
    d = '{8'h1E, 8'h2F, 8'hE0};
    run_frame("good3", 3, d, 8'hD0, 0);

    // Same frame, bad checksum.
    run_frame("badcs", 3, d, 8'hD1, 0);

    // Illegal lengths, then a good frame clears err.
    d = '{};
    run_frame("len0", 0, d, 8'h00, 0);
    run_frame("len17", 17, d, 8'h00, 0);
    d = '{8'h01, 8'h02};
    run_frame("after_badlen", 2, d, good_csum(2, d), 0);

    // Full 16-byte frame, random in_valid gaps, with a SYNC value as data.
    d = '{};
    for (int i = 0; i < 16; i++) d.push_back(8'($urandom));
    d[$urandom_range(0, 15)] = LOADER_SYNC;
    run_frame("full16", 16, d, good_csum(16, d), 40);

    // Random frames: random length (occasionally illegal), random checksum quality, leading junk.
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        cs = 8'($urandom);
        if (cs == LOADER_SYNC) cs = 8'h5A;
        drive(cs, 20);
      end
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 255)) : int'($urandom_range(1, 16));
      d = '{};
      if (len <= 16) for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      cs = good_csum(len, d);
      if ($urandom_range(0, 2) == 0) cs = cs + 8'($urandom_range(1, 255));
      run_frame("rand", len, d, cs, 30);
    end

    // Reset mid-frame after two data bytes of a 5-byte frame.
    drive(LOADER_SYNC, 0);
    drive(8'h05, 0);
    drive(8'h11, 0);
    drive(8'h22, 0);
    exp_mem[0] = 8'h11;
    exp_mem[1] = 8'h22;
    chk("midrst.we_before", 32'(ram_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst.ram_we", 32'(ram_we), 32'd0);
    chk("midrst.ram_addr", 32'(ram_addr), 32'd0);
    chk("midrst.ram_wdata", 32'(ram_wdata), 32'd0);
    chk("midrst.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.err", 32'(err), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    d = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_frame("post_rst", 5, d, good_csum(5, d), 0);

    // Cumulative RAM image, including bytes left by rejected frames.
    for (int i = 0; i < 16; i++) chk("ram_image", 32'(obs_mem[i]), 32'(exp_mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program loader for the SAP-1 RAM. It accepts a framed byte stream on a valid/ready interface and writes the payload into the 16x8 program memory. It sits between a host link (UART receiver or testbench) and the memory's write port, holding the CPU in reset while a frame is in flight. It releases the CPU only after a frame passes its checksum.

## Interface
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W
- DATA_W, 8, RAM/bus word width
- SYNC, 8'hA5, frame start byte
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- in_data  in  DATA_W  stream byte
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  loader can accept; transfer when in_valid && in_ready
- ram_we  out  1  one-cycle write strobe to program memory
- ram_addr  out  ADDR_W  write address
- ram_wdata  out  DATA_W  write data
- cpu_hold  out  1  drives CPU/controller reset; 1 = hold
- done  out  1  sticky: last frame loaded and verified
- err  out  1  sticky: last frame rejected

## Operation
- Frame: SYNC, LEN, LEN data bytes, CSUM.
  - LEN is valid in the range 1..2**ADDR_W.
  - Data is written to addresses 0..LEN-1 in order.
  - CSUM makes (LEN + data bytes + CSUM) mod 256 == 0.
- States: S_SYNC, S_LEN, S_DATA, S_CSUM.
- S_SYNC:
  - Bytes other than SYNC are consumed and discarded.
  - Accepting SYNC goes to S_LEN, clears done and err, and sets cpu_hold.
- S_LEN:
  - LEN of 0 or greater than 2**ADDR_W: set err, return to S_SYNC.
  - Otherwise load the remaining-count register with LEN, seed the 8-bit sum with LEN, zero the address counter, and go to S_DATA.
- S_DATA:
  - Each accepted byte produces one write (ram_we, ram_addr = address counter, ram_wdata = byte).
  - Each accepted byte also adds to the sum, increments the address, and decrements the remaining count.
  - After the last byte, go to S_CSUM.
- S_CSUM:
  - Accepted byte plus sum == 0 (mod 256): set done, clear cpu_hold.
  - Otherwise: set err and keep cpu_hold high.
  - Either way, return to S_SYNC.
- in_ready is 1 in every state. The loader never stalls the source; in_valid low simply pauses the frame.
- Arithmetic: sum is 8-bit wrapping. The address counter is ADDR_W bits and never wraps within a legal frame (LEN ≤ depth).
- A SYNC value arriving in S_LEN, S_DATA or S_CSUM is ordinary data, not a restart.
- A rejected frame leaves already-written RAM bytes in place. cpu_hold stays asserted until a good frame completes.

## Timing
- Reset values: state S_SYNC, in_ready 1, ram_we 0, ram_addr 0, ram_wdata 0, cpu_hold 1, done 0, err 0.
- ram_we, ram_addr and ram_wdata are registered. The write appears the cycle after the data byte is accepted, and ram_we lasts exactly one cycle per byte.
- Back-to-back accepted bytes give back-to-back write cycles.
- cpu_hold rises the cycle after SYNC is accepted.
- cpu_hold falls, and done rises, the cycle after a good CSUM is accepted. The final ram_we for the last data byte precedes this by at least one cycle.
- err rises the cycle after a bad LEN or bad CSUM is accepted.
- Reset asserted mid-frame: immediate return to reset values. cpu_hold goes 1 asynchronously; partial RAM contents are undefined to the CPU.
- Max throughput: one byte per cycle. A full 16-byte frame takes 19 accepted cycles.

## Structure
- Shared package `sap_pkg`:
  - state enum (S_SYNC, S_LEN, S_DATA, S_CSUM)
  - LOADER_SYNC = 8'hA5
  - RAM depth constant (16), shared with `memory`
- Single module. No sub-module is needed: counter, sum and FSM fit in one `always` block plus registered outputs.
- Top-level integration:
  - `cpu_hold` ORs into the CPU reset.
  - `ram_*` drives the memory's write port, muxed with nothing, since the CPU never writes RAM.

## Test plan
- Reset → in_ready 1, cpu_hold 1, done 0, err 0, ram_we 0.
- Stream 8'h00, 8'hA5, 8'h03, 8'h1E, 8'h2F, 8'hE0, CSUM 8'hD0 → leading 00 ignored; writes (0,1E),(1,2F),(2,E0) on consecutive cycles; done 1 and cpu_hold 0 one cycle after CSUM.
- Same frame with CSUM 8'hD1 → three writes occur, err 1, done 0, cpu_hold stays 1.
- A5, LEN 8'h00 and separately A5, LEN 8'h11 → no ram_we, err 1, FSM back in S_SYNC; a following good frame clears err.
- Full 16-byte frame with in_valid toggling randomly, including a data byte equal to 8'hA5 → 16 writes to addr 0..15 in order, A5 written as data, done 1.
- Drop rst low after two data bytes of a 5-byte frame → outputs return to reset values immediately; the next complete frame loads correctly from addr 0.
